// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: carries the memory-stage result into write-back,
// with flush/bubble handling, GPR and HI/LO forwarding, and retire/bubble counters.
module mem_wb_pipe #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int CP0_AW    = 5,
  parameter int STAGE     = 4,
  parameter int FWD_PORTS = 2,
  parameter int CNT_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [5:0]                  stall,
  input  logic                        flush,
  input  logic                        mem_valid,
  input  logic [REG_AW-1:0]           mem_wd,
  input  logic                        mem_wreg,
  input  logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_hi,
  input  logic [DATA_W-1:0]           mem_lo,
  input  logic                        mem_whilo,
  input  logic                        mem_LLbit_we,
  input  logic                        mem_LLbit_value,
  input  logic                        mem_cp0_we,
  input  logic [CP0_AW-1:0]           mem_cp0_addr,
  input  logic [DATA_W-1:0]           mem_cp0_data,
  output logic                        wb_valid,
  output logic [REG_AW-1:0]           wb_wd,
  output logic                        wb_wreg,
  output logic [DATA_W-1:0]           wb_wdata,
  output logic [DATA_W-1:0]           wb_hi,
  output logic [DATA_W-1:0]           wb_lo,
  output logic                        wb_whilo,
  output logic                        wb_LLbit_we,
  output logic                        wb_LLbit_value,
  output logic                        wb_cp0_we,
  output logic [CP0_AW-1:0]           wb_cp0_addr,
  output logic [DATA_W-1:0]           wb_cp0_data,
  input  logic [FWD_PORTS*REG_AW-1:0] rd_addr,
  output logic [FWD_PORTS-1:0]        fwd_hit,
  output logic [FWD_PORTS*DATA_W-1:0] fwd_data,
  output logic                        fwd_hilo_hit,
  output logic [DATA_W-1:0]           fwd_hi,
  output logic [DATA_W-1:0]           fwd_lo,
  input  logic                        cnt_clr,
  output logic [CNT_W-1:0]            retire_cnt,
  output logic [CNT_W-1:0]            bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              whilo;
    logic              llbit_we;
    logic              llbit_value;
    logic              cp0_we;
    logic [CP0_AW-1:0] cp0_addr;
    logic [DATA_W-1:0] cp0_data;
  } entry_t;

  entry_t            entry_d, entry_q;
  logic [CNT_W-1:0]  retire_cnt_d, retire_cnt_q;
  logic [CNT_W-1:0]  bubble_cnt_d, bubble_cnt_q;
  logic              do_bubble_s, do_advance_s;
  logic              retire_inc_s, bubble_inc_s;

  // Next entry: flush and bubble insert a NOP, advance loads, otherwise hold.
  always_comb begin
    entry_d      = entry_q;
    do_bubble_s  = stall[STAGE] & ~stall[STAGE+1];
    do_advance_s = ~stall[STAGE];
    if (flush || do_bubble_s) begin
      entry_d = '0;
    end else if (do_advance_s) begin
      entry_d.valid       = mem_valid;
      entry_d.wd          = mem_wd;
      entry_d.wreg        = mem_wreg & mem_valid;
      entry_d.wdata       = mem_wdata;
      entry_d.hi          = mem_hi;
      entry_d.lo          = mem_lo;
      entry_d.whilo       = mem_whilo & mem_valid;
      entry_d.llbit_we    = mem_LLbit_we & mem_valid;
      entry_d.llbit_value = mem_LLbit_value;
      entry_d.cp0_we      = mem_cp0_we & mem_valid;
      entry_d.cp0_addr    = mem_cp0_addr;
      entry_d.cp0_data    = mem_cp0_data;
    end else begin
      entry_d = entry_q;
    end
  end

  // Saturating counters; clear wins over an increment in the same cycle.
  always_comb begin
    retire_inc_s = do_advance_s & mem_valid & ~flush;
    bubble_inc_s = do_bubble_s & ~flush;
    retire_cnt_d = retire_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      retire_cnt_d = {CNT_W{1'b0}};
      bubble_cnt_d = {CNT_W{1'b0}};
    end else begin
      if (retire_inc_s && (retire_cnt_q != {CNT_W{1'b1}})) begin
        retire_cnt_d = retire_cnt_q + CNT_W'(1);
      end else begin
        retire_cnt_d = retire_cnt_q;
      end
      if (bubble_inc_s && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end else begin
        bubble_cnt_d = bubble_cnt_q;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      entry_q      <= '0;
      retire_cnt_q <= {CNT_W{1'b0}};
      bubble_cnt_q <= {CNT_W{1'b0}};
    end else begin
      entry_q      <= entry_d;
      retire_cnt_q <= retire_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Forwarding from the registered entry only; register 0 never forwards.
  always_comb begin
    fwd_hit      = {FWD_PORTS{1'b0}};
    fwd_data     = {(FWD_PORTS*DATA_W){1'b0}};
    fwd_hilo_hit = entry_q.valid & entry_q.whilo;
    fwd_hi       = {DATA_W{1'b0}};
    fwd_lo       = {DATA_W{1'b0}};
    for (int k = 0; k < FWD_PORTS; k++) begin
      if (entry_q.valid && entry_q.wreg && (entry_q.wd != {REG_AW{1'b0}}) &&
          (rd_addr[k*REG_AW +: REG_AW] == entry_q.wd)) begin
        fwd_hit[k]                  = 1'b1;
        fwd_data[k*DATA_W +: DATA_W] = entry_q.wdata;
      end else begin
        fwd_hit[k]                  = 1'b0;
        fwd_data[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end
    end
    if (fwd_hilo_hit) begin
      fwd_hi = entry_q.hi;
      fwd_lo = entry_q.lo;
    end else begin
      fwd_hi = {DATA_W{1'b0}};
      fwd_lo = {DATA_W{1'b0}};
    end
  end

  assign wb_valid       = entry_q.valid;
  assign wb_wd          = entry_q.wd;
  assign wb_wreg        = entry_q.wreg;
  assign wb_wdata       = entry_q.wdata;
  assign wb_hi          = entry_q.hi;
  assign wb_lo          = entry_q.lo;
  assign wb_whilo       = entry_q.whilo;
  assign wb_LLbit_we    = entry_q.llbit_we;
  assign wb_LLbit_value = entry_q.llbit_value;
  assign wb_cp0_we      = entry_q.cp0_we;
  assign wb_cp0_addr    = entry_q.cp0_addr;
  assign wb_cp0_data    = entry_q.cp0_data;
  assign retire_cnt     = retire_cnt_q;
  assign bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: directed scenarios plus random traffic against a
// behavioural model of the write-back entry, forwarding and counters.
module tb_mem_wb_pipe;
  localparam int DATA_W = 32, REG_AW = 5, CP0_AW = 5, STAGE = 4, FWD_PORTS = 2, CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, flush, mem_valid, mem_wreg, mem_whilo, mem_LLbit_we, mem_LLbit_value, mem_cp0_we, cnt_clr;
  logic [5:0] stall;
  logic [REG_AW-1:0] mem_wd;
  logic [DATA_W-1:0] mem_wdata, mem_hi, mem_lo, mem_cp0_data;
  logic [CP0_AW-1:0] mem_cp0_addr;
  logic wb_valid, wb_wreg, wb_whilo, wb_LLbit_we, wb_LLbit_value, wb_cp0_we, fwd_hilo_hit;
  logic [REG_AW-1:0] wb_wd;
  logic [DATA_W-1:0] wb_wdata, wb_hi, wb_lo, wb_cp0_data, fwd_hi, fwd_lo;
  logic [CP0_AW-1:0] wb_cp0_addr;
  logic [FWD_PORTS*REG_AW-1:0] rd_addr;
  logic [FWD_PORTS-1:0] fwd_hit;
  logic [FWD_PORTS*DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0] retire_cnt, bubble_cnt;

  int n_vec = 0;
  int n_err = 0;

  // reference state
  logic m_valid, m_wreg, m_whilo, m_llwe, m_llval, m_cp0we;
  logic [REG_AW-1:0] m_wd;
  logic [DATA_W-1:0] m_wdata, m_hi, m_lo, m_cp0data;
  logic [CP0_AW-1:0] m_cp0addr;
  int m_ret, m_bub;

  mem_wb_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CP0_AW(CP0_AW), .STAGE(STAGE),
                .FWD_PORTS(FWD_PORTS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_LLbit_we(mem_LLbit_we), .mem_LLbit_value(mem_LLbit_value),
    .mem_cp0_we(mem_cp0_we), .mem_cp0_addr(mem_cp0_addr), .mem_cp0_data(mem_cp0_data),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo), .wb_LLbit_we(wb_LLbit_we),
    .wb_LLbit_value(wb_LLbit_value), .wb_cp0_we(wb_cp0_we), .wb_cp0_addr(wb_cp0_addr),
    .wb_cp0_data(wb_cp0_data), .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .fwd_hilo_hit(fwd_hilo_hit), .fwd_hi(fwd_hi), .fwd_lo(fwd_lo),
    .cnt_clr(cnt_clr), .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge, written directly from the update-priority rules.
  task automatic model_edge();
    bit bubble, advance, clear;
    bubble  = stall[STAGE] && !stall[STAGE+1];
    advance = !stall[STAGE];
    clear   = !rst || flush || bubble;
    if (!rst) begin
      m_ret = 0; m_bub = 0;
    end else if (cnt_clr) begin
      m_ret = 0; m_bub = 0;
    end else begin
      if (advance && mem_valid && !flush && m_ret < CNT_MAX) m_ret++;
      if (bubble && !flush && m_bub < CNT_MAX) m_bub++;
    end
    if (clear) begin
      {m_valid, m_wreg, m_whilo, m_llwe, m_llval, m_cp0we} = 6'b0;
      m_wd = '0; m_wdata = '0; m_hi = '0; m_lo = '0; m_cp0data = '0; m_cp0addr = '0;
    end else if (advance) begin
      m_valid = mem_valid;       m_wd = mem_wd;
      m_wreg  = mem_wreg && mem_valid;   m_wdata = mem_wdata;
      m_hi = mem_hi; m_lo = mem_lo;      m_whilo = mem_whilo && mem_valid;
      m_llwe = mem_LLbit_we && mem_valid; m_llval = mem_LLbit_value;
      m_cp0we = mem_cp0_we && mem_valid;  m_cp0addr = mem_cp0_addr; m_cp0data = mem_cp0_data;
    end
  endtask

  task automatic check_all();
    logic [REG_AW-1:0] a;
    bit hit;
    check_eq("wb_valid", 64'(wb_valid), 64'(m_valid));
    check_eq("wb_wd", 64'(wb_wd), 64'(m_wd));
    check_eq("wb_wreg", 64'(wb_wreg), 64'(m_wreg));
    check_eq("wb_wdata", 64'(wb_wdata), 64'(m_wdata));
    check_eq("wb_hi", 64'(wb_hi), 64'(m_hi));
    check_eq("wb_lo", 64'(wb_lo), 64'(m_lo));
    check_eq("wb_whilo", 64'(wb_whilo), 64'(m_whilo));
    check_eq("wb_llwe", 64'(wb_LLbit_we), 64'(m_llwe));
    check_eq("wb_llval", 64'(wb_LLbit_value), 64'(m_llval));
    check_eq("wb_cp0we", 64'(wb_cp0_we), 64'(m_cp0we));
    check_eq("wb_cp0addr", 64'(wb_cp0_addr), 64'(m_cp0addr));
    check_eq("wb_cp0data", 64'(wb_cp0_data), 64'(m_cp0data));
    for (int k = 0; k < FWD_PORTS; k++) begin
      a = rd_addr[k*REG_AW +: REG_AW];
      hit = m_valid && m_wreg && (m_wd != 0) && (a == m_wd);
      check_eq($sformatf("fwd_hit%0d", k), 64'(fwd_hit[k]), 64'(hit));
      check_eq($sformatf("fwd_data%0d", k), 64'(fwd_data[k*DATA_W +: DATA_W]),
               hit ? 64'(m_wdata) : 64'd0);
    end
    hit = m_valid && m_whilo;
    check_eq("fwd_hilo_hit", 64'(fwd_hilo_hit), 64'(hit));
    check_eq("fwd_hi", 64'(fwd_hi), hit ? 64'(m_hi) : 64'd0);
    check_eq("fwd_lo", 64'(fwd_lo), hit ? 64'(m_lo) : 64'd0);
    check_eq("retire_cnt", 64'(retire_cnt), 64'(m_ret));
    check_eq("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    m_ret = 0; m_bub = 0;
    {m_valid, m_wreg, m_whilo, m_llwe, m_llval, m_cp0we} = 6'b0;
    m_wd = '0; m_wdata = '0; m_hi = '0; m_lo = '0; m_cp0data = '0; m_cp0addr = '0;
    rst = 1'b0; stall = 6'b0; flush = 1'b0; cnt_clr = 1'b0;
    mem_valid = 1'b1; mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'hDEADBEEF;
    mem_hi = 32'h1111; mem_lo = 32'h2222; mem_whilo = 1'b1;
    mem_LLbit_we = 1'b0; mem_LLbit_value = 1'b0; mem_cp0_we = 1'b0;
    mem_cp0_addr = 5'd0; mem_cp0_data = 32'h0;
    rd_addr = {5'd5, 5'd5};

    // reset holds everything at zero
    cycle(); cycle();
    check_eq("rst_wdata", 64'(wb_wdata), 64'd0);
    check_eq("rst_fwd_hit", 64'(fwd_hit), 64'd0);

    rst = 1'b1;
    cycle();
    check_eq("adv_wd", 64'(wb_wd), 64'd5);
    check_eq("adv_wdata", 64'(wb_wdata), 64'hDEADBEEF);
    check_eq("adv_valid", 64'(wb_valid), 64'd1);
    check_eq("adv_retire", 64'(retire_cnt), 64'd1);

    // hold then bubble
    mem_wd = 5'd3; cycle();
    stall = 6'b110000; mem_wd = 5'd12; mem_wdata = 32'hCAFE0000;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("hold_wd", 64'(wb_wd), 64'd3);
    check_eq("hold_retire", 64'(retire_cnt), 64'd2);
    stall = 6'b010000; cycle();
    check_eq("bubble_valid", 64'(wb_valid), 64'd0);
    check_eq("bubble_cnt", 64'(bubble_cnt), 64'd1);

    // flush overrides downstream stall
    stall = 6'b000000; mem_wd = 5'd7; cycle();
    stall = 6'b110000; flush = 1'b1; cycle();
    check_eq("flush_valid", 64'(wb_valid), 64'd0);
    check_eq("flush_bubble", 64'(bubble_cnt), 64'd1);
    flush = 1'b0; stall = 6'b000000;

    // forwarding on port 0 only; register 0 never hits
    mem_wd = 5'd9; mem_wreg = 1'b1; mem_wdata = 32'h1234; rd_addr = {5'd4, 5'd9};
    cycle();
    check_eq("fwd_hit_p0", 64'(fwd_hit), 64'b01);
    check_eq("fwd_data_p0", 64'(fwd_data[31:0]), 64'h1234);
    check_eq("fwd_data_p1", 64'(fwd_data[63:32]), 64'd0);
    mem_wd = 5'd0; rd_addr = {5'd0, 5'd0}; cycle();
    check_eq("fwd_r0", 64'(fwd_hit), 64'd0);

    // invalid slot suppresses enables; valid slot passes LLbit
    mem_valid = 1'b0; mem_wreg = 1'b1; mem_LLbit_we = 1'b1; cycle();
    check_eq("inv_wreg", 64'(wb_wreg), 64'd0);
    check_eq("inv_llwe", 64'(wb_LLbit_we), 64'd0);
    mem_valid = 1'b1; mem_LLbit_value = 1'b1; cycle();
    check_eq("ll_we", 64'(wb_LLbit_we), 64'd1);
    check_eq("ll_val", 64'(wb_LLbit_value), 64'd1);

    // saturation and clear-priority
    cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
    for (int i = 0; i < 16; i++) cycle();
    check_eq("ret_sat", 64'(retire_cnt), 64'hF);
    cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
    check_eq("ret_clr", 64'(retire_cnt), 64'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 31) != 0);
      flush           = ($urandom_range(0, 7) == 0);
      cnt_clr         = ($urandom_range(0, 15) == 0);
      stall           = 6'($urandom);
      mem_valid       = ($urandom_range(0, 3) != 0);
      mem_wd          = 5'($urandom_range(0, 7));
      mem_wreg        = 1'($urandom);
      mem_wdata       = $urandom;
      mem_hi          = $urandom;
      mem_lo          = $urandom;
      mem_whilo       = 1'($urandom);
      mem_LLbit_we    = 1'($urandom);
      mem_LLbit_value = 1'($urandom);
      mem_cp0_we      = 1'($urandom);
      mem_cp0_addr    = 5'($urandom);
      mem_cp0_data    = $urandom;
      rd_addr         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
